// File: rtl/chipper_ejector_pkg.sv
// Shared router constants: link direction indices, address layout and flit record.
package chipper_ejector_pkg;

    localparam int DIR_E    = 0;
    localparam int DIR_W    = 1;
    localparam int DIR_N    = 2;
    localparam int DIR_S    = 3;
    localparam int NUM_DIRS = 4;

    // Node address is {row[2:0], col[2:0]}
    localparam int ADDR_W  = 6;
    localparam int ROW_MSB = 5;
    localparam int ROW_LSB = 3;
    localparam int COL_MSB = 2;
    localparam int COL_LSB = 0;

    localparam int FLIT_DATA_W = 16;

    typedef struct packed {
        logic                   valid;
        logic [ADDR_W-1:0]      addr;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    function automatic logic [ADDR_W-1:0] node_addr(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chipper_eject_fifo.sv
// Local ejection buffer: circular first-word-fall-through FIFO. Head reads as zero when empty.
module chipper_eject_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    // A push into a full buffer is only taken when the head leaves in the same cycle
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Next-state pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(pop_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage array carries no reset; stale entries are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= wdata_i;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/chipper_ejector.sv
// Ejection stage: removes at most one flit addressed to this node per cycle (round-robin
// among competing links), buffers it for the core, and registers all other link traffic.
module chipper_ejector
    import chipper_ejector_pkg::*;
#(
    parameter logic [2:0] LOCAL_ROW  = 3'd4,
    parameter logic [2:0] LOCAL_COL  = 3'd4,
    parameter int         DATA_W     = 16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_DIRS-1:0]                 in_valid,
    input  logic [NUM_DIRS-1:0][ADDR_W-1:0]     in_addr,
    input  logic [NUM_DIRS-1:0][DATA_W-1:0]     in_data,
    output logic [NUM_DIRS-1:0]                 out_valid,
    output logic [NUM_DIRS-1:0][ADDR_W-1:0]     out_addr,
    output logic [NUM_DIRS-1:0][DATA_W-1:0]     out_data,
    output logic                                local_valid,
    output logic [ADDR_W-1:0]                   local_addr,
    output logic [DATA_W-1:0]                   local_data,
    input  logic                                local_ready,
    output logic                                eject_defl
);

    localparam logic [ADDR_W-1:0] LOCAL_ADDR = node_addr(LOCAL_ROW, LOCAL_COL);
    localparam int                ENTRY_W    = ADDR_W + DATA_W;
    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_DIRS-1:0]             hit;
    logic                            pop, can_push;
    logic                            found, grant_vld;
    logic [1:0]                      scan_idx, grant_idx;
    logic [NUM_DIRS-1:0]             grant_oh;

    logic [1:0]                      rr_q, rr_d;
    logic [NUM_DIRS-1:0]             out_valid_q, out_valid_d;
    logic [NUM_DIRS-1:0][ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [NUM_DIRS-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic                            defl_q, defl_d;

    logic [ENTRY_W-1:0]              fifo_wdata, fifo_rdata;
    logic                            fifo_full, fifo_empty;
    logic [CNT_W-1:0]                fifo_count;

    assign local_valid = !fifo_empty;
    assign {local_addr, local_data} = fifo_rdata;
    assign pop        = local_valid && local_ready;
    assign can_push   = (fifo_count < CNT_W'(FIFO_DEPTH)) || pop;

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign eject_defl = defl_q;

    // Local match per link; invalid links never match
    always_comb begin
        for (int i = 0; i < NUM_DIRS; i++) begin
            hit[i] = in_valid[i] && (in_addr[i] == LOCAL_ADDR);
        end
    end

    // Round-robin scan from rr; the first hit wins only if the buffer can take it
    always_comb begin
        found     = 1'b0;
        grant_idx = rr_q;
        scan_idx  = rr_q;
        for (int k = 0; k < NUM_DIRS; k++) begin
            scan_idx = rr_q + 2'(k);
            if (!found && hit[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant_vld  = found && can_push;
        grant_oh   = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
        fifo_wdata = {in_addr[grant_idx], in_data[grant_idx]};
    end

    // Pass-through next state: granted link is cleared, everything else (incl. deflected hits) copies
    always_comb begin
        out_valid_d = in_valid;
        out_addr_d  = in_addr;
        out_data_d  = in_data;
        if (grant_vld) begin
            out_valid_d[grant_idx] = 1'b0;
            out_addr_d[grant_idx]  = '0;
            out_data_d[grant_idx]  = '0;
        end
        rr_d   = grant_vld ? grant_idx + 2'd1 : rr_q;
        defl_d = |(hit & ~grant_oh);
    end

    // Link output registers, arbiter pointer and deflection flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            rr_q        <= '0;
            defl_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            rr_q        <= rr_d;
            defl_q      <= defl_d;
        end
    end

    chipper_eject_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (grant_vld),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Full flag and occupancy must agree
    a_full_count: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: doc/chipper_ejector.md
# chipper_ejector

Ejection stage of the bufferless mesh router; it is the counterpart of the local injector. Each cycle it examines the four incoming link flits (east, west, north, south), selects at most one flit addressed to this node, removes it from the link and buffers it for the local core. All other flits pass through, registered, toward the injector and routing stage. A fixed-priority-free round-robin arbiter keeps competing local-bound flits fair; un-ejected local flits stay on the link and are deflected.

## Interface
- LOCAL_ROW, 3'd4, this node's row (addr[5:3])
- LOCAL_COL, 3'd4, this node's column (addr[2:0])
- DATA_W, 16, payload width per flit
- FIFO_DEPTH, 4, local ejection buffer entries (power of two, ≥2)

Ports; index order everywhere is 0 = east, 1 = west, 2 = north, 3 = south:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  4  flit present on link i
- in_addr  in  4×6  destination {row[2:0], col[2:0]} per link
- in_data  in  4×DATA_W  payload per link
- out_valid  out  4  registered pass-through valid
- out_addr  out  4×6  registered pass-through address
- out_data  out  4×DATA_W  registered pass-through payload
- local_valid  out  1  head of ejection FIFO valid
- local_addr  out  6  head address
- local_data  out  DATA_W  head payload
- local_ready  in  1  core accepts head
- eject_defl  out  1  registered: ≥1 local-bound flit was left on the link last cycle

## Operation
- Match: hit[i] = in_valid[i] && in_addr[i] == {LOCAL_ROW, LOCAL_COL}.
- Space: can_push = (count < FIFO_DEPTH) || (local_valid && local_ready).
- Arbiter: pointer rr[1:0]. Scan rr, rr+1, rr+2, rr+3 (mod 4). The first i with hit[i] is granted if can_push. On a grant, rr <= grant+1 mod 4. With no grant, rr holds its value.
- Granted flit: pushed into the FIFO. out_valid[grant] <= 0, and out_addr/out_data of that link <= 0.
- All other links: out_* <= in_* unchanged. This includes non-granted hits, which are deflected.
- eject_defl <= |(hit & ~grant_onehot).
- FIFO: a synchronous circular buffer. Pop occurs when local_valid && local_ready. Simultaneous push and pop keeps count constant and is legal when full.
- Invalid links (in_valid = 0) never hit. Their out_addr/out_data pass through but are don't-care.

## Timing
- Pass-through latency is 1 cycle.
- Ejection latency: flit at input on edge N appears on local_valid/local_addr/local_data after edge N (first-word-fall-through, visible in cycle N+1).
- local_* holds stable while local_valid && !local_ready.
- Reset (rst_n = 0 at an edge) clears the following:
  - out_valid = 0, out_addr = 0, out_data = 0
  - local_valid = 0, count = 0, FIFO pointers = 0
  - rr = 0, eject_defl = 0
- FIFO contents are discarded on reset mid-operation.
- Full with no pop in the same cycle means no grant: all hits pass through and eject_defl = 1 next cycle.
- Empty FIFO: local_valid = 0, and local_ready is ignored.
- Pointer wrap: rr = 3 with a grant on link 3 gives rr = 0. FIFO read and write pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.

## Structure
- Shared router package holds:
  - direction indices DIR_E = 0, DIR_W = 1, DIR_N = 2, DIR_S = 3
  - ADDR_W = 6
  - row/column field slices
  - flit struct {valid, addr, data}
- The injector uses the same constants.
- One sub-module, chipper_eject_fifo (parameters DATA_W + 6 and FIFO_DEPTH, push/pop/full/empty/count), holds the buffer. Match, arbitration and pass-through registers live in the top.

## Test plan
- Single hit: north carries addr 6'h24, data 16'hABCD; others carry 6'h11.
  - Next cycle: out_valid = 4'b1011, local_valid = 1, local_addr = 6'h24, local_data = 16'hABCD.
- Four simultaneous hits from reset (rr = 0): grant east.
  - West, north and south pass with valid and eject_defl = 1.
  - rr = 1.
  - Repeating the stimulus grants west, then north, then south, then east.
- Backpressure: local_ready = 0 with 5 consecutive single hits on link 0.
  - First 4 are ejected; the 5th passes on out_valid[0] with eject_defl = 1.
  - Releasing local_ready drains 4 flits in order.
- Full plus pop: FIFO full, local_ready = 1, hit on south.
  - South is ejected, count stays 4, and no deflection occurs.
- Reset mid-stream: rst_n low for one cycle while the FIFO holds 3 entries.
  - All outputs are 0 next cycle and rr = 0.
  - A subsequent hit on west ejects normally.
- Non-local traffic: all links valid with addr 6'h23, 6'h2C, 6'h04, 6'h3C.
  - All four pass unchanged with 1-cycle latency; local_valid stays 0.
